// File: rtl/v_mul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// v_mul_pkg : shared types for the pipelined SIMD multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
package v_mul_pkg;

   localparam int XLEN_MAX = 64;
   localparam int TAG_MAX  = 16;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHU  = 2'b10,
      MULHSU = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      SEW8  = 2'b00,
      SEW16 = 2'b01,
      SEW32 = 2'b10,
      SEW64 = 2'b11
   } sew_e;

   // Zero when the element is wider than the datapath.
   function automatic int lanes(input sew_e sew, input int xlen);
      return xlen / (8 << int'(sew));
   endfunction

   typedef struct packed {
      logic [XLEN_MAX-1:0] a;
      logic [XLEN_MAX-1:0] b;
      opcode_e             opcode;
      sew_e                sew;
      logic [TAG_MAX-1:0]  tag;
      logic                err;
   } payload_t;

endpackage
`default_nettype wire

// File: rtl/v_mul_lane_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// v_mul_lane_array : 8x8 block partial products and per-SEW lane summation
// Rev 1.0
// ----------------------------------------------------------------------------
module v_mul_lane_array
   import v_mul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]        pa_i,
   input  logic [XLEN-1:0]        pb_i,
   input  sew_e                   psew_i,
   output logic [XLEN*XLEN/4-1:0] pp_o,
   input  logic [XLEN*XLEN/4-1:0] pp_i,
   input  logic [XLEN-1:0]        a_i,
   input  logic [XLEN-1:0]        b_i,
   input  opcode_e                op_i,
   input  sew_e                   sew_i,
   output logic [XLEN-1:0]        res_o
);

   localparam int NB = XLEN / 8;

   // Byte pairs that straddle a lane boundary are forced to zero.
   always_comb begin
      pp_o = '0;
      for (int i = 0; i < NB; i++) begin
         for (int j = 0; j < NB; j++) begin
            if ((i >> int'(psew_i)) == (j >> int'(psew_i)))
               pp_o[(i*NB+j)*16 +: 16] = 16'(pa_i[i*8 +: 8]) * 16'(pb_i[j*8 +: 8]);
         end
      end
   end

   logic [XLEN-1:0] res_s [4];

   for (genvar s = 0; s < 4; s++) begin : g_sew
      localparam int SEW = 8 << s;
      localparam int BPL = SEW / 8;
      localparam int NL  = lanes(sew_e'(s), XLEN);

      if (NL > 0) begin : g_lanes
         logic [XLEN-1:0] r;

         always_comb begin
            logic [2*SEW-1:0] acc;
            logic [2*SEW-1:0] t;
            logic [SEW-1:0]   la;
            logic [SEW-1:0]   lb;
            logic [SEW-1:0]   hi;
            r = '0;
            for (int l = 0; l < NL; l++) begin
               la  = a_i[l*SEW +: SEW];
               lb  = b_i[l*SEW +: SEW];
               acc = '0;
               for (int i = 0; i < BPL; i++) begin
                  for (int j = 0; j < BPL; j++) begin
                     t       = '0;
                     t[15:0] = pp_i[((l*BPL+i)*NB + l*BPL+j)*16 +: 16];
                     acc     = acc + (t << (8*(i+j)));
                  end
               end
               // Unsigned product corrected to signed: subtract the other
               // operand from the high half for each negative signed input.
               hi = acc[2*SEW-1:SEW];
               if ((op_i == MULH || op_i == MULHSU) && la[SEW-1])
                  hi = hi - lb;
               if (op_i == MULH && lb[SEW-1])
                  hi = hi - la;
               r[l*SEW +: SEW] = (op_i == MUL) ? acc[SEW-1:0] : hi;
            end
         end

         assign res_s[s] = r;
      end else begin : g_none
         assign res_s[s] = '0;
      end
   end

   assign res_o = res_s[sew_i];

endmodule
`default_nettype wire

// File: rtl/v_mult_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// v_mult_pipe : elastic valid/ready pipelined SIMD integer multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
module v_mult_pipe
   import v_mul_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  operand_a,
   input  logic [XLEN-1:0]  operand_b,
   input  logic [1:0]       opcode,
   input  logic [1:0]       precision,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  mul_out,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int PPW  = XLEN * XLEN / 4;
   localparam int LAST = PIPE_STAGES - 1;

   payload_t               in_pl;
   logic [PPW-1:0]         in_pp;
   payload_t               stg_q [PIPE_STAGES];
   payload_t               stg_d [PIPE_STAGES];
   logic [PPW-1:0]         pp_q  [PIPE_STAGES];
   logic [PPW-1:0]         pp_d  [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] vld_q;
   logic [PIPE_STAGES-1:0] vld_d;
   logic [PIPE_STAGES-1:0] adv;
   logic                   accept;
   logic [XLEN-1:0]        res;
   logic                   unused_payload;

   always_comb begin
      in_pl                  = '0;
      in_pl.a[XLEN-1:0]      = operand_a;
      in_pl.b[XLEN-1:0]      = operand_b;
      in_pl.opcode           = opcode_e'(opcode);
      in_pl.sew              = sew_e'(precision);
      in_pl.tag[TAG_W-1:0]   = in_tag;
      in_pl.err              = (XLEN == 32) && (precision == 2'b11);
   end

   // A stage advances unless it and every stage after it are full while the
   // consumer stalls; written flat to avoid a ripple through adv itself.
   always_comb begin
      logic full;
      adv = '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
         full = 1'b1;
         for (int m = k; m < PIPE_STAGES; m++)
            full = full & vld_q[m];
         adv[k] = out_ready || !full;
      end
   end

   assign in_ready = rst && !flush && adv[0];
   assign accept   = in_valid && in_ready;

   always_comb begin
      vld_d = vld_q;
      stg_d = stg_q;
      pp_d  = pp_q;
      if (flush) begin
         vld_d = '0;
      end else begin
         if (adv[0])
            vld_d[0] = accept;
         if (accept) begin
            stg_d[0] = in_pl;
            pp_d[0]  = in_pp;
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (adv[k]) begin
               vld_d[k] = vld_q[k-1];
               stg_d[k] = stg_q[k-1];
               pp_d[k]  = pp_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         stg_q <= '{default: '0};
         pp_q  <= '{default: '0};
      end else begin
         vld_q <= vld_d;
         stg_q <= stg_d;
         pp_q  <= pp_d;
      end
   end

   v_mul_lane_array #(
      .XLEN (XLEN)
   ) u_lanes (
      .pa_i   (operand_a),
      .pb_i   (operand_b),
      .psew_i (sew_e'(precision)),
      .pp_o   (in_pp),
      .pp_i   (pp_q[LAST]),
      .a_i    (stg_q[LAST].a[XLEN-1:0]),
      .b_i    (stg_q[LAST].b[XLEN-1:0]),
      .op_i   (stg_q[LAST].opcode),
      .sew_i  (stg_q[LAST].sew),
      .res_o  (res)
   );

   assign out_valid = vld_q[LAST];
   assign mul_out   = (out_valid && !stg_q[LAST].err) ? res : '0;
   assign out_tag   = out_valid ? stg_q[LAST].tag[TAG_W-1:0] : '0;
   assign out_err   = out_valid && stg_q[LAST].err;

   assign unused_payload = ^stg_q[LAST];

endmodule
`default_nettype wire
